// File: rtl/fx_slave.sv
// fx_slave: byte-wide register slave on the fx bus with a free-running
// microsecond counter and a small byte-stream FIFO. It responds to the
// 256-byte window whose upper address byte equals mod_id.
module fx_slave #(
    parameter logic [7:0] VERSION    = 8'h11,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        pluse_us,
    input  logic [7:0]  mod_id,
    input  logic [15:0] fx_waddr,
    input  logic        fx_wr,
    input  logic [7:0]  fx_data,
    input  logic        fx_rd,
    input  logic [15:0] fx_raddr,
    output logic [7:0]  fx_q,
    output logic [7:0]  ctrl_out,
    output logic [7:0]  st_data,
    output logic        st_valid,
    input  logic        st_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Register offsets inside the module window
    localparam logic [7:0] OFF_VERSION = 8'h00;
    localparam logic [7:0] OFF_CTRL    = 8'h01;
    localparam logic [7:0] OFF_STATUS  = 8'h02;
    localparam logic [7:0] OFF_TIME_L  = 8'h03;
    localparam logic [7:0] OFF_TIME_H  = 8'h04;
    localparam logic [7:0] OFF_FIFO    = 8'h05;
    localparam logic [7:0] OFF_OVF     = 8'h06;

    logic [7:0]    ctrl;
    logic [15:0]   time_us;
    logic [7:0]    time_h;
    logic [7:0]    ovf;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic       wr_hit;
    logic       rd_hit;
    logic [7:0] wr_off;
    logic [7:0] rd_off;
    logic       empty;
    logic       full;
    logic       ovf_nz;
    logic       pop;
    logic       push_req;
    logic       push_ok;
    logic       ovf_inc;
    logic       ovf_clr;
    logic [7:0] rd_mux;

    // Overflow counter sticks at its maximum instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign wr_hit = fx_wr && (fx_waddr[15:8] == mod_id);
    assign rd_hit = fx_rd && (fx_raddr[15:8] == mod_id);
    assign wr_off = fx_waddr[7:0];
    assign rd_off = fx_raddr[7:0];

    assign empty  = (count == '0);
    assign full   = (count == CW'(FIFO_DEPTH));
    assign ovf_nz = (ovf != 8'h00);

    // st_valid is forced low while reset is held so no pop can happen then
    assign st_valid = !empty && !rst;
    assign st_data  = mem[rd_ptr];
    assign pop      = st_valid && st_ready;

    // A pop in the same cycle frees a slot, so a push at full still lands
    assign push_req = wr_hit && (wr_off == OFF_FIFO);
    assign push_ok  = push_req && (!full || pop);
    assign ovf_inc  = push_req && full && !pop;
    assign ovf_clr  = wr_hit && (wr_off == OFF_OVF);

    assign ctrl_out = ctrl;

    // Read data selection from the current (pre-write) register values
    always_comb begin
        rd_mux = 8'h00;
        if (rd_hit) begin
            case (rd_off)
                OFF_VERSION: rd_mux = VERSION;
                OFF_CTRL:    rd_mux = ctrl;
                OFF_STATUS:  rd_mux = {5'b0, ovf_nz, full, empty};
                OFF_TIME_L:  rd_mux = time_us[7:0];
                OFF_TIME_H:  rd_mux = time_h;
                OFF_FIFO:    rd_mux = 8'(count);
                OFF_OVF:     rd_mux = ovf;
                default:     rd_mux = 8'h00;
            endcase
        end
    end

    // Register file, timer, TIME_H shadow, overflow counter and read port
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            ctrl    <= 8'h00;
            time_us <= 16'h0000;
            time_h  <= 8'h00;
            ovf     <= 8'h00;
            fx_q    <= 8'h00;
        end else begin
            if (wr_hit && (wr_off == OFF_CTRL))
                ctrl <= fx_data;
            if (pluse_us)
                time_us <= time_us + 16'd1;
            if (rd_hit && (rd_off == OFF_TIME_L))
                time_h <= time_us[15:8];
            if (ovf_clr)
                ovf <= 8'h00;
            else if (ovf_inc)
                ovf <= sat_inc8(ovf);
            if (fx_rd)
                fx_q <= rd_mux;
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo the depth
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage carries data only, so it is left out of reset
    always_ff @(posedge clk_sys) begin
        if (push_ok)
            mem[wr_ptr] <= fx_data;
    end

endmodule

// File: tb/tb_fx_slave.sv
// tb_fx_slave: directed bench for fx_slave with hand-computed expectations.
module tb_fx_slave;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        pluse_us = 1'b0;
    logic [7:0]  mod_id = 8'h3A;
    logic [15:0] fx_waddr = 16'h0000;
    logic        fx_wr = 1'b0;
    logic [7:0]  fx_data = 8'h00;
    logic        fx_rd = 1'b0;
    logic [15:0] fx_raddr = 16'h0000;
    logic [7:0]  fx_q;
    logic [7:0]  ctrl_out;
    logic [7:0]  st_data;
    logic        st_valid;
    logic        st_ready = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    fx_slave #(.VERSION(8'h11), .FIFO_DEPTH(8)) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .pluse_us (pluse_us),
        .mod_id   (mod_id),
        .fx_waddr (fx_waddr),
        .fx_wr    (fx_wr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q),
        .ctrl_out (ctrl_out),
        .st_data  (st_data),
        .st_valid (st_valid),
        .st_ready (st_ready)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_read(input logic [15:0] addr, output logic [7:0] data);
        @(negedge clk_sys);
        fx_rd    = 1'b1;
        fx_raddr = addr;
        @(posedge clk_sys);
        #1;
        data  = fx_q;
        fx_rd = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk_sys);
        fx_wr    = 1'b1;
        fx_waddr = addr;
        fx_data  = data;
        @(posedge clk_sys);
        #1;
        fx_wr = 1'b0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            pluse_us = 1'b1;
        end
        @(negedge clk_sys);
        pluse_us = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        vec_cnt++;
        if (fx_q !== 8'h00) begin
            err_cnt++; $display("FAIL reset_fx_q: got %h want 00", fx_q);
        end
        vec_cnt++;
        if (ctrl_out !== 8'h00) begin
            err_cnt++; $display("FAIL reset_ctrl: got %h want 00", ctrl_out);
        end
        vec_cnt++;
        if (st_valid !== 1'b0) begin
            err_cnt++; $display("FAIL reset_st_valid: got %b want 0", st_valid);
        end
    endtask

    task automatic test_version();
        logic [7:0] d;
        // Release reset and read on the very first edge afterwards
        @(negedge clk_sys);
        rst      = 1'b0;
        fx_rd    = 1'b1;
        fx_raddr = 16'h3A00;
        @(posedge clk_sys);
        #1;
        fx_rd = 1'b0;
        vec_cnt++;
        if (fx_q !== 8'h11) begin
            err_cnt++; $display("FAIL version_first_edge: got %h want 11", fx_q);
        end
        @(posedge clk_sys);
        #1;
        vec_cnt++;
        if (fx_q !== 8'h11) begin
            err_cnt++; $display("FAIL fx_q_hold: got %h want 11", fx_q);
        end
        do_read(16'h3B00, d);
        vec_cnt++;
        if (d !== 8'h00) begin
            err_cnt++; $display("FAIL miss_read: got %h want 00", d);
        end
        do_read(16'h3A00, d);
        do_read(16'h3A07, d);
        vec_cnt++;
        if (d !== 8'h00) begin
            err_cnt++; $display("FAIL unmapped_read: got %h want 00", d);
        end
    endtask

    task automatic test_ctrl();
        do_write(16'h3A01, 8'h5C);
        vec_cnt++;
        if (ctrl_out !== 8'h5C) begin
            err_cnt++; $display("FAIL ctrl_write: got %h want 5c", ctrl_out);
        end
        do_write(16'h3B01, 8'hAA);
        vec_cnt++;
        if (ctrl_out !== 8'h5C) begin
            err_cnt++; $display("FAIL ctrl_miss_write: got %h want 5c", ctrl_out);
        end
        @(negedge clk_sys);
        fx_wr    = 1'b1;
        fx_waddr = 16'h3A01;
        fx_data  = 8'h77;
        fx_rd    = 1'b1;
        fx_raddr = 16'h3A01;
        @(posedge clk_sys);
        #1;
        fx_wr = 1'b0;
        fx_rd = 1'b0;
        vec_cnt++;
        if (fx_q !== 8'h5C) begin
            err_cnt++; $display("FAIL rd_wr_collision: got %h want 5c", fx_q);
        end
        vec_cnt++;
        if (ctrl_out !== 8'h77) begin
            err_cnt++; $display("FAIL ctrl_after_collision: got %h want 77", ctrl_out);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] d;
        st_ready = 1'b0;
        // First push: st_valid must still be low before the sampling edge
        @(negedge clk_sys);
        fx_wr    = 1'b1;
        fx_waddr = 16'h3A05;
        fx_data  = 8'h01;
        #1;
        vec_cnt++;
        if (st_valid !== 1'b0) begin
            err_cnt++; $display("FAIL valid_same_cycle: got %b want 0", st_valid);
        end
        @(posedge clk_sys);
        #1;
        fx_wr = 1'b0;
        vec_cnt++;
        if (st_valid !== 1'b1) begin
            err_cnt++; $display("FAIL valid_next_cycle: got %b want 1", st_valid);
        end
        for (int i = 2; i <= 9; i++) do_write(16'h3A05, 8'(i));
        do_read(16'h3A05, d);
        vec_cnt++;
        if (d !== 8'h08) begin
            err_cnt++; $display("FAIL count_full: got %h want 08", d);
        end
        do_read(16'h3A02, d);
        vec_cnt++;
        if (d !== 8'h06) begin
            err_cnt++; $display("FAIL status_full_ovf: got %h want 06", d);
        end
        do_read(16'h3A06, d);
        vec_cnt++;
        if (d !== 8'h01) begin
            err_cnt++; $display("FAIL ovf_one: got %h want 01", d);
        end
        @(negedge clk_sys);
        st_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            vec_cnt++;
            if (st_valid !== 1'b1 || st_data !== 8'(i)) begin
                err_cnt++;
                $display("FAIL pop_order[%0d]: got valid=%b data=%h want valid=1 data=%h",
                         i, st_valid, st_data, 8'(i));
            end
            @(negedge clk_sys);
        end
        vec_cnt++;
        if (st_valid !== 1'b0) begin
            err_cnt++; $display("FAIL drained_valid: got %b want 0", st_valid);
        end
        st_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 8; i++) do_write(16'h3A05, 8'h10 + 8'(i));
        // Push and pop together while full
        @(negedge clk_sys);
        st_ready = 1'b1;
        fx_wr    = 1'b1;
        fx_waddr = 16'h3A05;
        fx_data  = 8'h18;
        @(posedge clk_sys);
        #1;
        fx_wr    = 1'b0;
        st_ready = 1'b0;
        vec_cnt++;
        if (st_data !== 8'h11) begin
            err_cnt++; $display("FAIL head_after_pushpop: got %h want 11", st_data);
        end
        do_read(16'h3A05, d);
        vec_cnt++;
        if (d !== 8'h08) begin
            err_cnt++; $display("FAIL count_pushpop: got %h want 08", d);
        end
        do_read(16'h3A06, d);
        vec_cnt++;
        if (d !== 8'h01) begin
            err_cnt++; $display("FAIL ovf_pushpop: got %h want 01", d);
        end
        do_write(16'h3A06, 8'h00);
        do_read(16'h3A06, d);
        vec_cnt++;
        if (d !== 8'h00) begin
            err_cnt++; $display("FAIL ovf_clear: got %h want 00", d);
        end
        do_read(16'h3A02, d);
        vec_cnt++;
        if (d !== 8'h02) begin
            err_cnt++; $display("FAIL status_after_clear: got %h want 02", d);
        end
        // 256 overflowing pushes must stop at FF
        for (int i = 0; i < 256; i++) do_write(16'h3A05, 8'hEE);
        do_read(16'h3A06, d);
        vec_cnt++;
        if (d !== 8'hFF) begin
            err_cnt++; $display("FAIL ovf_saturate: got %h want ff", d);
        end
        vec_cnt++;
        if (st_data !== 8'h11) begin
            err_cnt++; $display("FAIL head_after_overflow: got %h want 11", st_data);
        end
        do_write(16'h3A06, 8'h00);
        @(negedge clk_sys);
        st_ready = 1'b1;
        repeat (8) @(negedge clk_sys);
        st_ready = 1'b0;
        do_read(16'h3A05, d);
        vec_cnt++;
        if (d !== 8'h00) begin
            err_cnt++; $display("FAIL count_drained: got %h want 00", d);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        for (int i = 0; i < 5; i++) do_write(16'h3A05, 8'h40 + 8'(i));
        do_write(16'h3A01, 8'hFF);
        do_read(16'h3A05, d);
        vec_cnt++;
        if (d !== 8'h05) begin
            err_cnt++; $display("FAIL count_five: got %h want 05", d);
        end
        do_read(16'h3A00, d);
        @(negedge clk_sys);
        rst      = 1'b1;
        st_ready = 1'b1;
        fx_wr    = 1'b1;
        fx_waddr = 16'h3A01;
        fx_data  = 8'h55;
        #1;
        vec_cnt++;
        if (st_valid !== 1'b0) begin
            err_cnt++; $display("FAIL valid_during_reset: got %b want 0", st_valid);
        end
        @(posedge clk_sys);
        #1;
        vec_cnt++;
        if (ctrl_out !== 8'h00 || fx_q !== 8'h00 || st_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_reset: got ctrl=%h fx_q=%h valid=%b want 00 00 0",
                     ctrl_out, fx_q, st_valid);
        end
        @(negedge clk_sys);
        rst      = 1'b0;
        st_ready = 1'b0;
        fx_wr    = 1'b0;
        do_read(16'h3A05, d);
        vec_cnt++;
        if (d !== 8'h00 || st_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL count_after_reset: got count=%h valid=%b want 00 0", d, st_valid);
        end
    endtask

    task automatic test_time();
        logic [7:0] d;
        pulses(300);
        do_read(16'h3A03, d);
        vec_cnt++;
        if (d !== 8'h2C) begin
            err_cnt++; $display("FAIL time_l_300: got %h want 2c", d);
        end
        pulses(300);
        do_read(16'h3A04, d);
        vec_cnt++;
        if (d !== 8'h01) begin
            err_cnt++; $display("FAIL time_h_shadow: got %h want 01", d);
        end
        do_read(16'h3A03, d);
        vec_cnt++;
        if (d !== 8'h58) begin
            err_cnt++; $display("FAIL time_l_600: got %h want 58", d);
        end
        do_read(16'h3A04, d);
        vec_cnt++;
        if (d !== 8'h02) begin
            err_cnt++; $display("FAIL time_h_relatch: got %h want 02", d);
        end
    endtask

    initial begin
        test_reset();
        test_version();
        test_ctrl();
        test_fifo_overflow();
        test_back_to_back();
        test_mid_reset();
        test_time();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fx_slave.md
FX_SLAVE -- requirements
Module: fx_slave

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- VERSION, 8'h11, constant returned at offset 0x00.
- FIFO_DEPTH, 8, stream FIFO entries (power of 2).
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk_sys  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pluse_us  in  1  one-cycle strobe per microsecond.
- mod_id  in  8  module address; selects window {mod_id, 8'hxx}.
- fx_waddr  in  16  write address from the fx bus master.
- fx_wr  in  1  write strobe, one cycle per byte.
- fx_data  in  8  write data.
- fx_rd  in  1  read strobe, one cycle per byte.
- fx_raddr  in  16  read address.
- fx_q  out  8  registered read data.
- ctrl_out  out  8  CTRL register contents.
- st_data  out  8  stream FIFO head byte.
- st_valid  out  1  FIFO non-empty.
- st_ready  in  1  downstream pop when high with st_valid.

Function
REQ-003 An access hits when address[15:8] == mod_id. Non-hit writes shall be ignored. Non-hit reads shall load fx_q with 8'h00.
REQ-004 Register map (offset = address[7:0]):
- 0x00 RO VERSION.
- 0x01 RW CTRL.
- 0x02 RO STATUS {5'b0, ovf_nz, full, empty}.
- 0x03 RO TIME_L.
- 0x04 RO TIME_H shadow.
- 0x05 WO FIFO push / RO FIFO count.
- 0x06 OVF count; any write clears it.
- Others: reads return 8'h00, writes ignored.
REQ-005 Read latency is exactly 1 cycle: fx_q shall update on the edge that samples fx_rd=1 and hold its value until the next fx_rd.
REQ-006 A write to 0x01 shall update CTRL and ctrl_out on the sampling edge.
REQ-007 When fx_wr and fx_rd target the same register in the same cycle, fx_q shall return the pre-write value.
REQ-008 time_us is a 16-bit counter that increments on pluse_us and wraps from 16'hFFFF to 0.
REQ-009 A read of 0x03 shall return time_us[7:0] and, on the same edge, latch time_us[15:8] into the TIME_H shadow. A read of 0x04 shall return the shadow.
REQ-010 A write to 0x05 shall push fx_data when the FIFO is not full.
REQ-011 A write to 0x05 while full shall discard the data and increment OVF, saturating at 8'hFF.
REQ-012 Simultaneous push and pop while full: the pop frees the slot, the push is accepted, and OVF is unchanged.
REQ-013 A pop occurs when st_valid && st_ready. st_data shows the head entry combinationally from the FIFO storage.
REQ-014 A push into an empty FIFO shall raise st_valid on the following cycle, never in the same cycle.
REQ-015 The FIFO count is 0..FIFO_DEPTH, with width log2(FIFO_DEPTH)+1. empty = (count==0); full = (count==FIFO_DEPTH). Read/write pointers wrap modulo FIFO_DEPTH.
REQ-016 A write to 0x06 concurrent with an overflowing push shall leave OVF = 0 (clear wins).
REQ-017 ovf_nz = (OVF != 0).

Reset
REQ-018 While rst=1 on a clock edge, the following shall be 0: fx_q, CTRL/ctrl_out, time_us, TIME_H shadow, OVF, FIFO pointers and count.
REQ-019 During reset, st_valid shall be 0 and fx_wr/fx_rd/st_ready shall be ignored. FIFO contents are discarded even if reset is asserted mid-stream.
REQ-020 After rst deasserts, the first fx access shall be honoured on the first edge.

Verification
REQ-021 mod_id=8'h3A; rd 0x3A00 -> fx_q=8'h11 next cycle. rd 0x3B00 -> fx_q=8'h00.
REQ-022 wr 0x3A01=8'h5C -> ctrl_out=8'h5C. Same-cycle wr 0x3A01=8'h77 and rd 0x3A01 -> fx_q=8'h5C, then ctrl_out=8'h77.
REQ-023 With st_ready=0, push 9 bytes 0x01..0x09 -> count=8, STATUS=8'h06, OVF=1. Then st_ready=1 -> st_data pops 0x01..0x08 in order, st_valid=0 after the 8th pop.
REQ-024 Full FIFO with st_ready=1 and a simultaneous push -> push accepted, count stays 8, OVF unchanged. Wr 0x3A06 -> OVF=0, STATUS bit2=0.
REQ-025 Drive 300 pluse_us strobes -> rd 0x3A03 returns 8'h2C. Then 300 more strobes, rd 0x3A04 returns 8'h01 (latched value, not live 8'h02).
REQ-026 Assert rst for one cycle mid-stream with count=5 and CTRL=8'hFF -> count=0, st_valid=0, ctrl_out=0, fx_q=0 on the next cycle.
